tetris_move_sched: RTL and testbench

- Schedules all piece-move commands into the board-update engine, which accepts one move at a time.
- Arbitrates between four requesters: left, right and rotate button pulses (already synchronized and debounced upstream), plus an internal gravity tick.
- Issues moves over a valid/ack handshake.
- Reports piece lock when a gravity step is rejected.

---
 rtl/tetris_move_sched.sv | 136 +++++++++++++
 tb/tb_tetris_move_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_move_sched.sv
// Move-command scheduler: arbitrates button requests and gravity ticks into a
// single outstanding valid/ack command for the board engine, and flags piece lock.
module tetris_move_sched #(
    parameter int TICK_DIV = 50000000,
    parameter int FAST_DIV = 5000000,
    parameter int CW       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       soft_drop,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    output logic       move_valid,
    output logic [2:0] move_op,
    input  logic       move_ack,
    input  logic       move_ok,
    output logic       lock_pulse,
    output logic       busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_DOWN  = 3'd4;

    localparam logic [CW-1:0] TICK_M1 = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] FAST_M1 = CW'(FAST_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_l_q, pend_l_d;
    logic          pend_r_q, pend_r_d;
    logic          pend_rot_q, pend_rot_d;
    logic          pend_dn_q, pend_dn_d;

    logic [CW-1:0] period_m1;
    logic          tick;
    logic          flush;
    logic          clr_l, clr_r, clr_rot, clr_dn;

    assign period_m1 = soft_drop ? FAST_M1 : TICK_M1;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        cnt_d   = cnt_q;
        tick    = 1'b0;
        state_d = state_q;
        op_d    = op_q;
        flush   = 1'b0;
        clr_l   = 1'b0;
        clr_r   = 1'b0;
        clr_rot = 1'b0;
        clr_dn  = 1'b0;

        // ">=" rather than "==" so a switch to the fast period past its end ticks at once.
        if (!en || state_q == S_LOCK) begin
            cnt_d = '0;
        end else if (cnt_q >= period_m1) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!en) begin
                    flush = 1'b1;
                end else if (pend_dn_q || pend_rot_q || pend_l_q || pend_r_q) begin
                    state_d = S_ISSUE;
                    if (pend_dn_q)       op_d = OP_DOWN;
                    else if (pend_rot_q) op_d = OP_ROT;
                    else if (pend_l_q)   op_d = OP_LEFT;
                    else                 op_d = OP_RIGHT;
                end
            end
            S_ISSUE: begin
                if (move_ack) begin
                    clr_l   = (op_q == OP_LEFT);
                    clr_r   = (op_q == OP_RIGHT);
                    clr_rot = (op_q == OP_ROT);
                    clr_dn  = (op_q == OP_DOWN);
                    state_d = (op_q == OP_DOWN && !move_ok) ? S_LOCK : S_IDLE;
                end
            end
            S_LOCK: begin
                clr_l   = 1'b1;
                clr_r   = 1'b1;
                clr_rot = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new request in the same cycle as its clear keeps the flag set.
        pend_l_d   = !flush && (btn_left  || (pend_l_q   && !clr_l));
        pend_r_d   = !flush && (btn_right || (pend_r_q   && !clr_r));
        pend_rot_d = !flush && (btn_rot   || (pend_rot_q && !clr_rot));
        pend_dn_d  = !flush && (tick      || (pend_dn_q  && !clr_dn));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NONE;
            cnt_q      <= '0;
            pend_l_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            pend_rot_q <= 1'b0;
            pend_dn_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            pend_rot_q <= pend_rot_d;
            pend_dn_q  <= pend_dn_d;
        end
    end

    assign move_valid = (state_q == S_ISSUE);
    assign busy       = (state_q == S_ISSUE);
    assign move_op    = (state_q == S_ISSUE) ? op_q : OP_NONE;
    assign lock_pulse = (state_q == S_LOCK);

endmodule

// File: tb/tb_tetris_move_sched.sv
// Directed bench for tetris_move_sched with TICK_DIV=8, FAST_DIV=2.
module tb_tetris_move_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       soft_drop = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_rot = 1'b0;
    logic       move_valid;
    logic [2:0] move_op;
    logic       move_ack = 1'b0;
    logic       move_ok = 1'b1;
    logic       lock_pulse;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int n;

    tetris_move_sched #(.TICK_DIV(8), .FAST_DIV(2), .CW(4)) dut (
        .clk(clk), .rst(rst), .en(en), .soft_drop(soft_drop),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot),
        .move_valid(move_valid), .move_op(move_op),
        .move_ack(move_ack), .move_ok(move_ok),
        .lock_pulse(lock_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until move_valid rises, bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!move_valid && cycles < 40);
    endtask

    // Ack the current command immediately, then count cycles to the next move_valid.
    task automatic ack_measure(output int cycles);
        move_ack = 1'b1;
        move_ok  = 1'b1;
        cycles   = 0;
        do begin
            step();
            move_ack = 1'b0;
            cycles++;
        end while (!move_valid && cycles < 40);
    endtask

    task automatic ack_now();
        move_ack = 1'b1;
        move_ok  = 1'b1;
        step();
        move_ack = 1'b0;
    endtask

    task automatic quiesce();
        en = 1'b0;
        step();
        step();
    endtask

    initial begin
        // Reset and free-running gravity
        repeat (3) step();
        check("rst_valid", move_valid, 0);
        check("rst_op", move_op, 0);
        check("rst_lock", lock_pulse, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        en  = 1'b1;
        wait_valid(n);
        check("first_down_latency", n, 9);
        check("first_down_op", move_op, 4);
        check("first_down_busy", busy, 1);
        ack_measure(n);
        check("gravity_period", n, 8);
        check("gravity_op", move_op, 4);
        ack_now();
        quiesce();
        check("quiet_valid", move_valid, 0);

        // Priority: tick, rot and left together
        en = 1'b1;
        repeat (7) step();
        btn_left = 1'b1;
        btn_rot  = 1'b1;
        step();
        btn_left = 1'b0;
        btn_rot  = 1'b0;
        check("prio_not_yet", move_valid, 0);
        step();
        check("prio_1_valid", move_valid, 1);
        check("prio_1_down", move_op, 4);
        step();
        check("prio_1_held", move_op, 4);
        ack_now();
        check("prio_gap_1", move_valid, 0);
        step();
        check("prio_2_rot", move_op, 3);
        ack_now();
        check("prio_gap_2", move_valid, 0);
        step();
        check("prio_3_left", move_op, 1);
        ack_now();
        quiesce();

        // Coalescing of right pulses during a slow LEFT
        en = 1'b1;
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        step();
        check("coal_left", move_op, 1);
        btn_right = 1'b1;
        step();
        btn_right = 1'b0;
        step();
        btn_right = 1'b1;
        step();
        btn_right = 1'b0;
        step();
        check("coal_left_held", move_op, 1);
        btn_right = 1'b1;
        move_ack  = 1'b1;
        move_ok   = 1'b1;
        step();
        btn_right = 1'b0;
        move_ack  = 1'b0;
        check("coal_gap", move_valid, 0);
        step();
        check("coal_right", move_op, 2);
        ack_now();
        check("coal_gap_2", move_valid, 0);
        step();
        check("coal_next_is_down", move_op, 4);
        ack_now();
        step();
        check("coal_no_second_right", move_valid, 0);
        quiesce();

        // Lock: DOWN rejected while LEFT pending
        en = 1'b1;
        repeat (7) step();
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        step();
        check("lock_down_op", move_op, 4);
        move_ack = 1'b1;
        move_ok  = 1'b0;
        step();
        move_ack = 1'b0;
        move_ok  = 1'b1;
        check("lock_pulse_on", lock_pulse, 1);
        check("lock_valid_low", move_valid, 0);
        step();
        check("lock_pulse_off", lock_pulse, 0);
        wait_valid(n);
        check("lock_restart_latency", n, 9);
        check("lock_no_left", move_op, 4);
        ack_now();
        quiesce();

        // Soft drop
        en = 1'b1;
        repeat (5) step();
        soft_drop = 1'b1;
        step();
        check("soft_tick_pending", move_valid, 0);
        step();
        check("soft_first_down", move_op, 4);
        ack_measure(n);
        check("soft_period_a", n, 2);
        ack_measure(n);
        check("soft_period_b", n, 2);
        soft_drop = 1'b0;
        ack_measure(n);
        check("soft_release_period", n, 8);
        ack_now();
        quiesce();

        // Abort: en dropped during ISSUE
        en = 1'b1;
        btn_rot = 1'b1;
        step();
        btn_rot = 1'b0;
        step();
        check("abort_rot", move_op, 3);
        en = 1'b0;
        btn_left = 1'b1;
        step();
        btn_left = 1'b0;
        step();
        step();
        check("abort_rot_held", move_op, 3);
        ack_now();
        check("abort_valid_drop", move_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort_no_grant", move_valid, 0);
        end
        en = 1'b1;
        wait_valid(n);
        check("abort_flags_flushed", n, 9);
        check("abort_resume_op", move_op, 4);

        // Reset mid-transaction, then a late rejecting ack
        rst = 1'b1;
        #1;
        check("async_rst_valid", move_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_op", move_op, 0);
        #1;
        rst = 1'b0;
        move_ack = 1'b1;
        move_ok  = 1'b0;
        step();
        move_ack = 1'b0;
        move_ok  = 1'b1;
        check("late_ack_no_lock", lock_pulse, 0);
        check("late_ack_no_valid", move_valid, 0);
        wait_valid(n);
        check("post_rst_latency", n, 8);
        check("post_rst_op", move_op, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
